// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side consumer for a FIFO with one-cycle read latency. Words are
//   popped from the FIFO and presented downstream as a valid/ready stream
//   at up to one word per clock. The pop request depends only on registered
//   state (buffer occupancy plus the one word that may be in flight), so
//   m_ready never reaches fifo_read combinationally.
//
// Parameters
//   DWIDTH     data width, equal to the FIFO's data width
//   BUF_DEPTH  output buffer entries (2..16); 3 or more sustains 1 word/cycle
//
// Ports
//   clk        FIFO read clock
//   rst        synchronous, active-high reset
//   fifo_read  pop request to the FIFO
//   fifo_dout  FIFO data, valid the cycle after fifo_read
//   fifo_empty FIFO empty flag
//   flush      drop buffered and in-flight words
//   m_valid    stream word available
//   m_ready    downstream accepts the word
//   m_data     stream data (don't-care while m_valid=0)
//   buf_count  occupied buffer entries
module fifo_stream_reader #(
  parameter int DWIDTH    = 32,
  parameter int BUF_DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           fifo_read,
  input  logic [DWIDTH-1:0]              fifo_dout,
  input  logic                           fifo_empty,
  input  logic                           flush,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DWIDTH-1:0]              m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int LW = CW + 1;
  localparam int PW = $clog2(BUF_DEPTH);

  localparam logic [LW-1:0] DEPTH_C  = LW'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

  logic [DWIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [CW-1:0]     count;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              inflight;
  logic              push;
  logic              pop;
  logic [LW-1:0]     credit;

  // Pointers wrap explicitly so BUF_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Occupancy plus the word already requested; one spare bit so the sum
  // cannot wrap before the comparison.
  assign credit    = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign fifo_read = !rst && !flush && !fifo_empty && (credit < DEPTH_C);

  // A word returned in the flush cycle belongs to the discarded stream.
  assign push = inflight && !flush;
  assign pop  = m_valid && m_ready;

  assign m_valid   = (count != '0);
  assign m_data    = buf_mem[head];
  assign buf_count = count;

  // Control state: request tracking, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_read;
      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Data storage: no reset, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) buf_mem[tail] <= fifo_dout;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count} <= DEPTH_C));

  a_no_read_empty: assert property (@(posedge clk)
    !(fifo_read && fifo_empty));

endmodule
